// File: rtl/serializer_8to1.sv
// Parallel-to-serial converter: accepts words over valid/ready and shifts them out LSB-first.
// A one-word holding register lets consecutive words stream with no idle serial cycle.
module serializer_8to1 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] datain,
    input  logic             validIn,
    output logic             readyIn,
    output logic             dataout,
    output logic             validOut,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic [CW-1:0]    bitcnt, bitcnt_n;
    logic [WIDTH-1:0] hold, hold_n;
    logic             hold_full, hold_full_n;
    logic             accept;

    // readyIn depends on registered state only, so there is no validIn-to-readyIn path.
    assign readyIn  = !hold_full;
    assign accept   = validIn && readyIn;
    assign validOut = (state == SHIFT);
    assign dataout  = (state == SHIFT) && shreg[0];
    assign busy     = (state == SHIFT) || hold_full;

    // NOTE: data registers are reset too, so no X can ever reach dataout or be reloaded from hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shreg     <= '0;
            bitcnt    <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
        end else begin
            state     <= state_n;
            shreg     <= shreg_n;
            bitcnt    <= bitcnt_n;
            hold      <= hold_n;
            hold_full <= hold_full_n;
        end
    end

    // NOTE: every next-state variable gets a default first; without it this block would infer latches.
    always_comb begin
        state_n     = state;
        shreg_n     = shreg;
        bitcnt_n    = bitcnt;
        hold_n      = hold;
        hold_full_n = hold_full;

        case (state)
            IDLE: begin
                if (accept) begin
                    shreg_n  = datain;
                    bitcnt_n = '0;
                    state_n  = SHIFT;
                end
            end
            SHIFT: begin
                if (bitcnt == LAST) begin
                    // Held word has priority; readyIn is low then, so no accept can collide.
                    if (hold_full) begin
                        shreg_n     = hold;
                        hold_full_n = 1'b0;
                        bitcnt_n    = '0;
                    end else if (accept) begin
                        shreg_n  = datain;
                        bitcnt_n = '0;
                    end else begin
                        shreg_n  = {1'b0, shreg[WIDTH-1:1]};
                        bitcnt_n = bitcnt + 1'b1;
                        state_n  = IDLE;
                    end
                end else begin
                    shreg_n  = {1'b0, shreg[WIDTH-1:1]};
                    bitcnt_n = bitcnt + 1'b1;
                    if (accept) begin
                        hold_n      = datain;
                        hold_full_n = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_serializer_8to1.sv
// Scoreboard bench for serializer_8to1: accepted words are expanded into an expected bit stream,
// and a negedge monitor compares the serial output and handshake flags against that stream.
module tb_serializer_8to1;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [WIDTH-1:0] datain = '0;
    logic             validIn = 1'b0;
    logic             readyIn;
    logic             dataout;
    logic             validOut;
    logic             busy;

    int checks = 0;
    int errors = 0;

    // Reference model: the serial line is just the LSB-first bits of every accepted word, in order.
    logic exp_q[$];
    logic exp_bit;

    serializer_8to1 #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .datain   (datain),
        .validIn  (validIn),
        .readyIn  (readyIn),
        .dataout  (dataout),
        .validOut (validOut),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Output is valid whenever bits are pending; a second pending word means the hold register is full.
    always @(negedge clk) begin
        if (rst_n) begin
            check("validOut", int'(validOut), int'(exp_q.size() > 0));
            check("busy",     int'(busy),     int'(exp_q.size() > 0));
            check("readyIn",  int'(readyIn),  int'(exp_q.size() <= WIDTH));
            if (exp_q.size() > 0) begin
                exp_bit = exp_q.pop_front();
                check("dataout", int'(dataout), int'(exp_bit));
            end else begin
                check("dataout_idle", int'(dataout), 0);
            end
        end
    end

    // One cycle of stimulus; entered just after a posedge, returns just after the next posedge.
    task automatic drive_cycle(input logic v, input logic [WIDTH-1:0] d, output logic acc);
        validIn = v;
        datain  = d;
        @(negedge clk);
        acc = validIn && readyIn;
        @(posedge clk);
        #1;
        if (acc) begin
            for (int i = 0; i < WIDTH; i++) exp_q.push_back(d[i]);
        end
    endtask

    task automatic idle_cycles(input int n);
        logic acc;
        for (int i = 0; i < n; i++) drive_cycle(1'b0, WIDTH'($urandom), acc);
    endtask

    // Holds validIn high until each word is accepted, with a bounded wait per word.
    task automatic send_words(input int n, input logic [WIDTH-1:0] w0,
                              input logic [WIDTH-1:0] w1, input logic [WIDTH-1:0] w2);
        logic [WIDTH-1:0] w;
        logic acc;
        int   tries;
        for (int k = 0; k < n; k++) begin
            w = (k == 0) ? w0 : (k == 1) ? w1 : w2;
            tries = 0;
            acc = 1'b0;
            while (!acc && tries < 4 * WIDTH) begin
                drive_cycle(1'b1, w, acc);
                tries++;
            end
            check("accept_timeout", int'(acc), 1);
        end
        validIn = 1'b0;
    endtask

    task automatic drain;
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 8 * WIDTH) begin
            idle_cycles(1);
            n++;
        end
        check("drain_empty", exp_q.size(), 0);
        idle_cycles(2);
    endtask

    initial begin
        logic acc;

        // Reset state
        #2;
        check("rst_validOut", int'(validOut), 0);
        check("rst_dataout",  int'(dataout),  0);
        check("rst_busy",     int'(busy),     0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        #1 check("rel_readyIn", int'(readyIn), 1);
        @(posedge clk);
        #1;

        // Single word 0xA5
        drive_cycle(1'b1, 8'hA5, acc);
        check("single_accept", int'(acc), 1);
        validIn = 1'b0;
        drain();

        // Back-to-back 0x3C, 0xF0 with validIn held
        send_words(2, 8'h3C, 8'hF0, 8'h00);
        drain();

        // Last-bit bypass: 0x80 presented exactly on the last-bit edge of 0x01
        drive_cycle(1'b1, 8'h01, acc);
        check("bypass_first", int'(acc), 1);
        idle_cycles(WIDTH - 1);
        drive_cycle(1'b1, 8'h80, acc);
        check("bypass_second", int'(acc), 1);
        validIn = 1'b0;
        drain();

        // Backpressure with three words
        send_words(3, 8'h11, 8'h22, 8'h33);
        drain();

        // Reset in the middle of 0xFF after three bits
        drive_cycle(1'b1, 8'hFF, acc);
        check("rstmid_accept", int'(acc), 1);
        validIn = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rstmid_validOut", int'(validOut), 0);
        check("rstmid_dataout",  int'(dataout),  0);
        check("rstmid_busy",     int'(busy),     0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        #1 check("rstmid_readyIn", int'(readyIn), 1);
        @(posedge clk);
        #1;

        // Idle input toggling: datain changes with validIn low
        idle_cycles(20);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive_cycle(($urandom_range(0, 3) != 0), WIDTH'($urandom), acc);
        end
        validIn = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
